// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake, flush,
// and a two-entry (main + skid) buffer. in_ready is registered, so it never
// depends combinationally on out_ready.
// Optional stall statistics are built only when PIPE_STAT_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 112,
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned DST_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DST_W-1:0]  in_dst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DST_W-1:0]  out_dst,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_nxt;
  logic   in_ready_q;

  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DST_W-1:0]  main_dst_q,  skid_dst_q;

  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  // State register and registered upstream ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

  // Next-state and storage load selection; flush overrides everything
  always_comb begin
    state_nxt    = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_nxt  = ST_ONE;
            ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            ld_main_in = 1'b1;
          end else if (in_valid) begin
            state_nxt = ST_FULL;
            ld_skid   = 1'b1;
          end else if (out_ready) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_nxt    = ST_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Main and skid entry storage; contents go stale (not cleared) on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_dst_q  <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_dst_q  <= '0;
    end else begin
      if (ld_main_in) begin
        main_data_q <= in_data;
        main_ctrl_q <= in_ctrl;
        main_dst_q  <= in_dst;
      end else if (ld_main_skid) begin
        main_data_q <= skid_data_q;
        main_ctrl_q <= skid_ctrl_q;
        main_dst_q  <= skid_dst_q;
      end
      if (ld_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
        skid_dst_q  <= in_dst;
      end
    end
  end

  // Output decode; control masked so a bubble never writes the register file
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = in_ready_q;
    out_data  = main_data_q;
    out_dst   = main_dst_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
  end

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles where downstream withholds ready; reset-only clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table for handshake/flush cases,
// hand-written sequences for reset, streaming and stall statistics.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 112;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned DST_W  = 3;
  localparam int unsigned NVEC   = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DST_W-1:0]  in_dst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DST_W-1:0]  out_dst;
  logic [15:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DST_W(DST_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_dst    (in_dst),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_dst   (out_dst),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic [DST_W-1:0]  dst;
    logic              fl;
    logic              ordy;
    logic              ov;
    logic              ir;
    logic [DATA_W-1:0] od;
    logic [CTRL_W-1:0] oc;
    logic [DST_W-1:0]  odst;
  } vec_t;

  vec_t vt [NVEC];

  function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic [5:0] c,
                              input logic [2:0] dst, input logic fl, input logic ordy,
                              input logic ov, input logic ir, input logic [15:0] od,
                              input logic [5:0] oc, input logic [2:0] odst);
    vec_t v;
    v.iv = iv; v.d = DATA_W'(d); v.c = c; v.dst = dst; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.od = DATA_W'(od); v.oc = oc; v.odst = odst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, sample on the next falling edge
  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic [DST_W-1:0] dst, input logic fl, input logic ordy);
    in_valid = iv; in_data = d; in_ctrl = c; in_dst = dst; flush = fl; out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0]       exp_cnt;
  logic [DATA_W-1:0] beat_abcd;

  initial begin
    beat_abcd = 112'hFEED_0000_0000_0000_0000_0000_ABCD;

    //            iv  d      c      dst fl ordy | ov ir od     oc     odst
    vt[0]  = mk(1, 16'h0A, 6'h01, 3'd1, 0, 0,   1, 1, 16'h0A, 6'h01, 3'd1);
    vt[1]  = mk(1, 16'h0B, 6'h02, 3'd2, 0, 0,   1, 0, 16'h0A, 6'h01, 3'd1);
    vt[2]  = mk(1, 16'h0C, 6'h03, 3'd3, 0, 0,   1, 0, 16'h0A, 6'h01, 3'd1);
    vt[3]  = mk(1, 16'h0C, 6'h03, 3'd3, 0, 1,   1, 1, 16'h0B, 6'h02, 3'd2);
    vt[4]  = mk(1, 16'h0C, 6'h03, 3'd3, 0, 1,   1, 1, 16'h0C, 6'h03, 3'd3);
    vt[5]  = mk(0, 16'h00, 6'h00, 3'd0, 0, 1,   0, 1, 16'h0C, 6'h00, 3'd3);
    vt[6]  = mk(1, 16'h11, 6'h3F, 3'd4, 0, 0,   1, 1, 16'h11, 6'h3F, 3'd4);
    vt[7]  = mk(1, 16'h22, 6'h3F, 3'd5, 0, 0,   1, 0, 16'h11, 6'h3F, 3'd4);
    vt[8]  = mk(1, 16'hDD, 6'h3F, 3'd6, 1, 0,   0, 1, 16'h11, 6'h00, 3'd4);
    vt[9]  = mk(0, 16'h00, 6'h00, 3'd0, 0, 0,   0, 1, 16'h11, 6'h00, 3'd4);
    vt[10] = mk(1, 16'hEE, 6'h05, 3'd7, 0, 0,   1, 1, 16'hEE, 6'h05, 3'd7);
    vt[11] = mk(1, 16'h33, 6'h3F, 3'd0, 1, 1,   0, 1, 16'hEE, 6'h00, 3'd7);
    vt[12] = mk(0, 16'h00, 6'h00, 3'd0, 0, 0,   0, 1, 16'hEE, 6'h00, 3'd7);
    vt[13] = mk(1, 16'h44, 6'h06, 3'd5, 0, 0,   1, 1, 16'h44, 6'h06, 3'd5);
    vt[14] = mk(0, 16'h00, 6'h00, 3'd0, 0, 0,   1, 1, 16'h44, 6'h06, 3'd5);
    vt[15] = mk(0, 16'h00, 6'h00, 3'd0, 0, 1,   0, 1, 16'h44, 6'h00, 3'd5);
    vt[16] = mk(0, 16'h99, 6'h3F, 3'd2, 0, 0,   0, 1, 16'h44, 6'h00, 3'd5);

    // Reset
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; in_dst = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst_out_dst",   128'(out_dst),   128'(0));
    chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    rst = 1'b1;
    @(negedge clk);

    // Back-pressure, flush and hold vectors
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].c, vt[i].dst, vt[i].fl, vt[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vt[i].ov));
      chk($sformatf("vec%0d_in_ready", i),  128'(in_ready),  128'(vt[i].ir));
      chk($sformatf("vec%0d_out_data", i),  128'(out_data),  128'(vt[i].od));
      chk($sformatf("vec%0d_out_ctrl", i),  128'(out_ctrl),  128'(vt[i].oc));
      chk($sformatf("vec%0d_out_dst", i),   128'(out_dst),   128'(vt[i].odst));
    end

    // Asynchronous reset while FULL
    drive(1'b1, DATA_W'(16'h51), 6'h11, 3'd1, 1'b0, 1'b0);
    drive(1'b1, DATA_W'(16'h52), 6'h12, 3'd2, 1'b0, 1'b0);
    chk("full_in_ready", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("mrst_in_ready",  128'(in_ready),  128'(1'b1));
    chk("mrst_out_ctrl",  128'(out_ctrl),  128'(0));
    chk("mrst_out_data",  128'(out_data),  128'(0));
    chk("mrst_stall_cnt", 128'(stall_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, beat_abcd, 6'h2A, 3'd6, 1'b0, 1'b1);
    chk("abcd_out_valid", 128'(out_valid), 128'(1'b1));
    chk("abcd_out_data",  128'(out_data),  128'(beat_abcd));
    chk("abcd_out_ctrl",  128'(out_ctrl),  128'(6'h2A));

    // Streaming: one beat per cycle, one cycle latency
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DATA_W'(k), CTRL_W'(k), DST_W'(k), 1'b0, 1'b1);
      chk($sformatf("stream%0d_out_data", k),  128'(out_data),  128'(k));
      chk($sformatf("stream%0d_out_valid", k), 128'(out_valid), 128'(1'b1));
      chk($sformatf("stream%0d_in_ready", k),  128'(in_ready),  128'(1'b1));
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    chk("stream_drain_valid", 128'(out_valid), 128'(1'b0));
    chk("stream_stall_cnt",   128'(stall_cnt), 128'(0));

    // Stall statistics
    drive(1'b1, DATA_W'(16'h5), 6'h01, 3'd1, 1'b0, 1'b0);
    repeat (10) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAT_EN
    exp_cnt = 16'd10;
`else
    exp_cnt = 16'd0;
`endif
    chk("stall_cnt_10", 128'(stall_cnt), 128'(exp_cnt));
    repeat (70000) @(posedge clk);
    @(negedge clk);
`ifdef PIPE_STAT_EN
    exp_cnt = 16'hFFFF;
`else
    exp_cnt = 16'd0;
`endif
    chk("stall_cnt_sat", 128'(stall_cnt), 128'(exp_cnt));
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("stall_flush_valid", 128'(out_valid), 128'(1'b0));
    chk("stall_cnt_flush",   128'(stall_cnt), 128'(exp_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
